// File: rtl/intt_scale_out.sv
// Last-layer INTT output stage: scales butterfly coefficient pairs by n^-1 mod q
// and serialises them into an indexed one-coefficient-per-beat stream.
module intt_scale_out #(
  parameter int Q     = 7681,
  parameter int N_INV = 7651,
  parameter int N     = 256,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_c0,
  input  logic [15:0] in_c1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_coef,
  output logic [7:0]  out_idx,
  output logic        busy,
  output logic        done
);

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid & ready are both high; valid never depends on ready.

  localparam int PW     = 29;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAIR_W = $clog2(N / 2 + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [PAIR_W-1:0] pairs_acc;

  logic              s1_v;
  logic [PW-1:0]     s1_p0;
  logic [PW-1:0]     s1_p1;
  logic              s2_v;
  logic [15:0]       s2_r0;
  logic [15:0]       s2_r1;

  logic [15:0]       mem_c0 [DEPTH];
  logic [15:0]       mem_c1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              half;
  logic [7:0]        idx;

  logic              run;
  logic [SUM_W-1:0]  credit_sum;
  logic              in_fire;
  logic              out_fire;
  logic              push;
  logic              pop;

  // Credits cover both FIFO occupancy and pairs still in the multiply pipe,
  // so the pipeline never has to stall and the FIFO can never overflow.
  assign run        = (state == S_RUN);
  assign credit_sum = SUM_W'(fifo_count) + SUM_W'(s1_v) + SUM_W'(s2_v);
  assign in_ready   = run && (pairs_acc < PAIR_W'(N / 2)) && (credit_sum < SUM_W'(DEPTH));
  assign in_fire    = in_valid && in_ready;

  assign out_valid  = run && (fifo_count != '0);
  assign out_coef   = out_valid ? (half ? mem_c1[rd_ptr] : mem_c0[rd_ptr]) : 16'd0;
  assign out_idx    = idx;
  assign out_fire   = out_valid && out_ready;
  assign busy       = run;

  assign push       = run && s2_v;
  assign pop        = out_fire && half;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_c0[wr_ptr] <= s2_r0;
      mem_c1[wr_ptr] <= s2_r1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pairs_acc  <= '0;
      s1_v       <= 1'b0;
      s1_p0      <= '0;
      s1_p1      <= '0;
      s2_v       <= 1'b0;
      s2_r0      <= '0;
      s2_r1      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      half       <= 1'b0;
      idx        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            pairs_acc  <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            half       <= 1'b0;
            idx        <= '0;
          end
        end

        S_RUN: begin
          s1_v <= in_fire;
          if (in_fire) begin
            s1_p0     <= PW'(in_c0) * PW'(N_INV);
            s1_p1     <= PW'(in_c1) * PW'(N_INV);
            pairs_acc <= pairs_acc + PAIR_W'(1);
          end

          // Full modular reduction, so unreduced inputs (>= Q) come out < Q.
          s2_v <= s1_v;
          if (s1_v) begin
            s2_r0 <= 16'(s1_p0 % PW'(Q));
            s2_r1 <= 16'(s1_p1 % PW'(Q));
          end

          if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
          endcase

          if (out_fire) begin
            half <= ~half;
            idx  <= idx + 8'd1;
            if (idx == 8'(N - 1)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_scale_out.sv
// Directed bench for intt_scale_out: reset, latency, arithmetic corners,
// ignored start, and a full frame with input gaps and output backpressure.
module tb_intt_scale_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_c0 = '0;
  logic [15:0] in_c1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_coef;
  logic [7:0]  out_idx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [15:0] got_coef[$];
  logic [7:0]  got_idx[$];
  logic [15:0] exp_q[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  intt_scale_out dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c0     (in_c0),
    .in_c1     (in_c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  // Output capture: values are stable at negedge and transfer on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_coef.push_back(out_coef);
      got_idx.push_back(out_idx);
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  function automatic logic [15:0] scale(input int v);
    return 16'((v * 7651) % 7681);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    got_coef.delete();
    got_idx.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    bit ok = 0;
    int n = 0;
    in_c0 = a;
    in_c1 = b;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_pair: pair (%0d,%0d) not accepted, got in_ready=0 expected accept within 200 cycles", a, b);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b expected 1 within 3000 cycles", done);
    end else begin
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_at_done: busy=%b expected 0", busy);
      end
      tests++;
      if (got_idx.size() == 0 || got_idx[got_idx.size()-1] !== 8'd255) begin
        fails++;
        $display("FAIL last_idx_before_done: captured=%0d expected last idx 255", got_idx.size());
      end
    end
  endtask

  task automatic test_reset();
    bit bad = 0;
    #12;
    tests++;
    if ({in_ready, out_valid, out_coef, out_idx, busy, done} !== 29'd0) begin
      fails++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b coef=%0d idx=%0d busy=%b done=%b expected all 0",
               in_ready, out_valid, out_coef, out_idx, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b0;
    send_pair(16'd10, 16'd11);
    send_pair(16'd12, 16'd13);
    send_pair(16'd14, 16'd15);
    repeat (3) tick();
    tests++;
    if (out_valid !== 1'b1 || out_coef !== scale(10)) begin
      fails++;
      $display("FAIL pre_reset_fifo: out_valid=%b coef=%0d expected 1 and %0d", out_valid, out_coef, scale(10));
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_coef, out_idx, busy, done} !== 29'd0) begin
      fails++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b coef=%0d idx=%0d busy=%b done=%b expected all 0",
               in_ready, out_valid, out_coef, out_idx, busy, done);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_c0 = 16'd5; in_c1 = 16'd6; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL no_start_no_accept: in_ready/out_valid/busy went high after reset, expected 0 without start");
    end
  endtask

  task automatic test_single_pair();
    clear_capture();
    out_ready = 1'b1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_before_start: busy=%b expected 0", busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: busy=%b expected 1", busy);
    end
    send_pair(16'd1, 16'd2);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_t0: out_valid=%b expected 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_t1: out_valid=%b expected 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_coef !== 16'd7651 || out_idx !== 8'd0) begin
      fails++;
      $display("FAIL single_c0: valid=%b coef=%0d idx=%0d expected 1 7651 0", out_valid, out_coef, out_idx);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_coef !== 16'd7621 || out_idx !== 8'd1) begin
      fails++;
      $display("FAIL single_c1: valid=%b coef=%0d idx=%0d expected 1 7621 1", out_valid, out_coef, out_idx);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drained: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_arith_corners();
    // 65535 = 4087 mod q and n^-1 = -30 mod q, so 65535*n^-1 = -122610 = 286 mod q.
    logic [15:0] exp_c [6] = '{16'd1, 16'd6781, 16'd0, 16'd0, 16'd286, 16'd30};
    send_pair(16'd256, 16'd30);
    send_pair(16'd7681, 16'd0);
    send_pair(16'd65535, 16'd7680);
    repeat (6) tick();
    tests++;
    if (got_coef.size() != 8) begin
      fails++;
      $display("FAIL corner_count: outputs=%0d expected 8", got_coef.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (got_coef[i+2] !== exp_c[i] || got_idx[i+2] !== 8'(i + 2)) begin
          fails++;
          $display("FAIL corner_%0d: coef=%0d idx=%0d expected %0d idx %0d",
                   i, got_coef[i+2], got_idx[i+2], exp_c[i], i + 2);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] a;
    logic [15:0] b;
    start = 1'b1; tick(); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || got_idx.size() != 8) begin
      fails++;
      $display("FAIL start_in_run: busy=%b outputs=%0d expected 1 and 8", busy, got_idx.size());
    end
    for (int k = 4; k < 128; k++) begin
      a = 16'(k * 511);
      b = 16'(65535 - k);
      exp_q.push_back(scale(int'(a)));
      exp_q.push_back(scale(int'(b)));
      send_pair(a, b);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_after_128_f2: in_ready=%b expected 0", in_ready);
    end
    wait_done();
    repeat (4) tick();
    tests++;
    if (done_cnt != 1 || got_idx.size() != 256) begin
      fails++;
      $display("FAIL frame2_totals: done_pulses=%0d outputs=%0d expected 1 and 256", done_cnt, got_idx.size());
    end
    for (int i = 0; i < got_idx.size() && i < 256; i++) begin
      tests++;
      if (got_idx[i] !== 8'(i) || (i >= 8 && exp_q.size() > 0 && got_coef[i] !== exp_q[0])) begin
        fails++;
        $display("FAIL frame2_out_%0d: idx=%0d coef=%0d expected idx %0d coef %0d",
                 i, got_idx[i], got_coef[i], i, (i >= 8 && exp_q.size() > 0) ? exp_q[0] : got_coef[i]);
      end
      if (i >= 8 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full_frame_backpressure();
    clear_capture();
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    fork
      begin
        for (int k = 0; k < 128; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_pair(16'(2 * k), 16'(2 * k + 1));
          if (k == 60) begin
            start = 1'b1; tick(); start = 1'b0;
          end
        end
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL in_ready_after_128: in_ready=%b expected 0", in_ready);
        end
      end
      begin
        logic [15:0] hold_c;
        logic [7:0]  hold_i;
        logic        hold_v;
        bit          stable = 1;
        int          n = 0;
        while (got_coef.size() < 40 && n < 2000) begin
          tick();
          n++;
        end
        out_ready = 1'b0;
        tick();
        hold_c = out_coef;
        hold_i = out_idx;
        hold_v = out_valid;
        repeat (19) begin
          tick();
          if (out_valid !== 1'b1 || out_coef !== hold_c || out_idx !== hold_i) stable = 0;
        end
        tests++;
        if (hold_v !== 1'b1 || !stable) begin
          fails++;
          $display("FAIL stall_stable: valid=%b coef=%0d idx=%0d held coef=%0d idx=%0d", out_valid, out_coef, out_idx, hold_c, hold_i);
        end
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_credit: in_ready=%b expected 0 with credits exhausted", in_ready);
        end
        out_ready = 1'b1;
      end
    join
    wait_done();
    repeat (4) tick();
    tests++;
    if (done_cnt != 1 || got_idx.size() != 256) begin
      fails++;
      $display("FAIL frame3_totals: done_pulses=%0d outputs=%0d expected 1 and 256", done_cnt, got_idx.size());
    end
    for (int i = 0; i < got_idx.size() && i < 256; i++) begin
      tests++;
      if (got_idx[i] !== 8'(i) || got_coef[i] !== scale(i)) begin
        fails++;
        $display("FAIL frame3_out_%0d: idx=%0d coef=%0d expected idx %0d coef %0d",
                 i, got_idx[i], got_coef[i], i, scale(i));
      end
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_frame: busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_arith_corners();
    test_start_ignored();
    test_full_frame_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
